mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter (CPU port A, loader/DMA port B) sharing one
// synchronous memory. Fixed three-state transaction: IDLE -> ACCESS -> COMPLETE.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        b_req,
    input  logic        a_we,
    input  logic        b_we,
    input  logic [15:0] a_addr,
    input  logic [15:0] b_addr,
    input  logic [15:0] a_wdata,
    input  logic [15:0] b_wdata,
    input  logic [15:0] mem_value,
    output logic        a_ack,
    output logic        b_ack,
    output logic [15:0] a_rdata,
    output logic [15:0] b_rdata,
    output logic [15:0] mem_address,
    output logic [15:0] mem_bus,
    output logic        mem_load,
    output logic        rom_wr_err,
    output logic [7:0]  err_count,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Handshake: a requester raises req with we/addr/wdata stable and keeps it high
    // until it sees its one-cycle ack; a req still high in the IDLE after the ack
    // is a new transaction. Fields are latched when the grant is taken.

    localparam logic [15:0] RAM_BASE = 16'h0100;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;   // 0 = A, 1 = B
    logic        g_port;
    logic        g_we;
    logic [15:0] g_addr;
    logic [15:0] g_wdata;

    logic        pick_b;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;

    // On a tie the port that was not served last wins.
    always_comb begin
        pick_b    = (a_req && b_req) ? ~last_grant : b_req;
        sel_we    = pick_b ? b_we    : a_we;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_wdata = pick_b ? b_wdata : a_wdata;
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            g_port      <= 1'b0;
            g_we        <= 1'b0;
            g_addr      <= 16'h0000;
            g_wdata     <= 16'h0000;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_rdata     <= 16'h0000;
            b_rdata     <= 16'h0000;
            mem_address <= 16'h0000;
            mem_bus     <= 16'h0000;
            mem_load    <= 1'b0;
            rom_wr_err  <= 1'b0;
            err_count   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        g_port      <= pick_b;
                        g_we        <= sel_we;
                        g_addr      <= sel_addr;
                        g_wdata     <= sel_wdata;
                        mem_address <= sel_addr;
                        mem_bus     <= sel_wdata;
                        mem_load    <= sel_we && (sel_addr >= RAM_BASE);
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_load <= 1'b0;
                    mem_bus  <= 16'h0000;
                    if (g_port) begin
                        b_ack <= 1'b1;
                    end else begin
                        a_ack <= 1'b1;
                    end
                    if (!g_we) begin
                        if (g_port) begin
                            b_rdata <= mem_value;
                        end else begin
                            a_rdata <= mem_value;
                        end
                    end else if (g_addr < RAM_BASE) begin
                        // ROM write: dropped, flagged and counted.
                        rom_wr_err <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end
                    state <= COMPLETE;
                end
                COMPLETE: begin
                    a_ack       <= 1'b0;
                    b_ack       <= 1'b0;
                    rom_wr_err  <= 1'b0;
                    mem_address <= 16'h0000;
                    last_grant  <= g_port;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model feeding an expected queue,
// with an independent monitor that checks every ack against it.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
    logic [15:0] a_addr = '0, b_addr = '0, a_wdata = '0, b_wdata = '0;
    logic [15:0] mem_value;
    logic        a_ack, b_ack, mem_load, rom_wr_err, busy;
    logic [15:0] a_rdata, b_rdata, mem_address, mem_bus;
    logic [7:0]  err_count;
    logic [1:0]  state_dbg;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
        .mem_value(mem_value),
        .a_ack(a_ack), .b_ack(b_ack), .a_rdata(a_rdata), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_bus(mem_bus), .mem_load(mem_load),
        .rom_wr_err(rom_wr_err), .err_count(err_count), .busy(busy),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory attached to the DUT ----------------
    logic [15:0] tb_mem  [0:65535];
    logic [15:0] ref_mem [0:65535];

    assign mem_value = tb_mem[mem_address];

    always @(posedge clk) begin
        if (mem_load) tb_mem[mem_address] <= mem_bus;
    end

    // ---------------- counters and check helper ----------------
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          port;     // 0 = A, 1 = B
        logic [15:0] addr;
        logic [15:0] rdata;
        bit          err;
        logic [7:0]  errcnt;
        int          loads;
        int          cycle;
    } exp_t;

    exp_t        exp_q[$];
    int          free_at = 0;
    bit          last_b  = 1'b1;
    int          m_err   = 0;
    logic [15:0] exp_rd [2];

    // Each posedge: if the arbiter is free and someone is asking, serve the port
    // that was not served last; the result appears one edge later, and the
    // arbiter is next free three edges after the grant.
    always @(posedge clk) begin
        exp_t        e;
        bit          p;
        bit          we;
        logic [15:0] ad;
        logic [15:0] wd;
        cyc++;
        if (reset) begin
            exp_q.delete();
            free_at   = cyc + 1;
            last_b    = 1'b1;
            m_err     = 0;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end else if (cyc >= free_at && (a_req || b_req)) begin
            if (a_req && b_req) p = !last_b;
            else                p = b_req;
            we = p ? b_we    : a_we;
            ad = p ? b_addr  : a_addr;
            wd = p ? b_wdata : a_wdata;
            e.port  = p;
            e.addr  = ad;
            e.err   = 1'b0;
            e.loads = 0;
            if (we) begin
                if (ad < 16'h0100) begin
                    e.err = 1'b1;
                    if (m_err < 255) m_err++;
                end else begin
                    ref_mem[ad] = wd;
                    e.loads = 1;
                end
            end else begin
                exp_rd[p] = ref_mem[ad];
            end
            e.rdata  = exp_rd[p];
            e.errcnt = 8'(m_err);
            e.cycle  = cyc + 1;
            exp_q.push_back(e);
            last_b  = p;
            free_at = cyc + 3;
        end
    end

    // ---------------- monitor ----------------
    int load_cnt = 0;

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (reset) load_cnt = 0;
        else if (mem_load) load_cnt++;
        if (rom_wr_err && !(a_ack || b_ack)) check("rom_wr_err_without_ack", 1, 0);
        if (a_ack || b_ack) begin
            check("single_ack", {31'd0, a_ack & b_ack}, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", {31'd0, b_ack}, {31'd0, e.port});
                check("ack_cycle", cyc, e.cycle);
                check("rdata", e.port ? b_rdata : a_rdata, e.rdata);
                check("rom_wr_err", {31'd0, rom_wr_err}, {31'd0, e.err});
                check("err_count", err_count, e.errcnt);
                check("mem_load_cycles", load_cnt, e.loads);
                check("mem_address_complete", mem_address, e.addr);
                check("mem_bus_complete", mem_bus, 0);
            end
            load_cnt = 0;
        end else if (exp_q.size() != 0 && exp_q[0].cycle < cyc) begin
            e = exp_q.pop_front();
            check("missing_ack", 0, 1);
        end
        if (!busy) begin
            check("idle_outputs", {mem_address, mem_bus}, 0);
            check("idle_strobes", {29'd0, mem_load, a_ack, b_ack}, 0);
        end
    end

    // ---------------- driver ----------------
    task automatic do_txn(input bit port, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input bit hold);
        bit got;
        @(negedge clk);
        if (!port) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            got = port ? b_ack : a_ack;
        end
        if (!got) check(port ? "b_ack_timeout" : "a_ack_timeout", 0, 1);
        if (!hold) begin
            @(negedge clk);
            if (!port) a_req = 1'b0;
            else       b_req = 1'b0;
        end
    endtask

    task automatic rand_port(input bit port, input int n);
        bit          we;
        bit          hold;
        logic [15:0] addr;
        for (int i = 0; i < n; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) addr = 16'($urandom_range(0, 255));
            else                           addr = 16'h0100 + 16'($urandom_range(0, 15));
            hold = (i != n - 1) && ($urandom_range(0, 7) == 0);
            do_txn(port, we, addr, 16'($urandom()), hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 65536; i++) begin
            tb_mem[i]  = 16'(i * 7) ^ 16'hA5A5;
            ref_mem[i] = 16'(i * 7) ^ 16'hA5A5;
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_rdata", {a_rdata, b_rdata}, 0);
        check("reset_err_count", err_count, 0);
        check("reset_flags", {28'd0, a_ack, b_ack, rom_wr_err, mem_load}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Tie from reset: A first; A re-requests while B waits, so B wins the next tie.
        fork
            begin
                do_txn(0, 0, 16'h0005, 16'h0000, 1);
                do_txn(0, 0, 16'h0200, 16'h0000, 0);
            end
            do_txn(1, 0, 16'h0010, 16'h0000, 0);
        join

        // Write then read back through the RAM region.
        do_txn(1, 1, 16'h1234, 16'hBEEF, 0);
        do_txn(1, 0, 16'h1234, 16'h0000, 0);
        check("b_readback", b_rdata, 16'hBEEF);

        // Held request produces back-to-back transactions three cycles apart.
        do_txn(0, 0, 16'h0105, 16'h0000, 1);
        do_txn(0, 0, 16'h1234, 16'h0000, 0);

        // ROM writes: rejected and counted, saturating.
        do_txn(0, 1, 16'h00FF, 16'hDEAD, 0);
        check("err_after_first", err_count, 1);
        for (int i = 0; i < 300; i++) begin
            do_txn(0, 1, 16'($urandom_range(0, 255)), 16'($urandom()), 0);
        end
        check("err_saturated", err_count, 255);

        // Reset while a B write is in ACCESS.
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0300; b_wdata = 16'h5A5A;
        @(negedge clk);
        check("abort_in_access", {31'd0, busy}, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_outputs", {mem_address, mem_bus}, 0);
        check("abort_flags", {28'd0, a_ack, b_ack, rom_wr_err, mem_load}, 0);
        check("abort_err_count", err_count, 0);
        check("abort_rdata", {a_rdata, b_rdata}, 0);
        @(negedge clk);
        reset = 1'b0;
        b_req = 1'b0;
        @(posedge clk);
        #1;
        check("abort_no_b_ack", {31'd0, b_ack}, 0);

        // Randomized concurrent traffic from both ports.
        fork
            rand_port(0, 60);
            rand_port(1, 60);
        join

        repeat (10) @(posedge clk);
        #2;
        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
